game_timer: RTL
===============

# game_timer

Parametrised countdown timer for the bomb game, sitting between the 1 Hz tick generator and the game-control FSM/display. While the game state is "game start" it counts seconds down from a programmable limit. It emits single-cycle interval and expiry pulses, applies time penalties on wrong inputs, supports pause, and raises a low-time warning level. It replaces the fixed 30-second/10-second timer with a generalised, display-capable version.

## Interface
Parameters:
- P_CNT_W, 6, width of remaining/elapsed counters; must satisfy 2^P_CNT_W > P_LIMIT
- P_LIMIT, 30, game length in seconds (1..2^P_CNT_W-1)
- P_INTERVAL, 10, elapsed-second period of o_IntervalTick (1..P_LIMIT)
- P_PENALTY, 3, seconds removed per i_Penalty pulse (0..P_LIMIT)
- P_WARN, 5, o_Warn asserted while remaining ≤ P_WARN

Ports:
- i_Clk  in  1  system clock (50 MHz)
- i_Rst  in  1  reset; one clock; reset is synchronous and active-low
- i_State  in  3  game state: 000 idle, 001 game_start, 010 game_clear, 011 game_fail (others treated as idle)
- i_Sec1Tick  in  1  one-cycle pulse per second
- i_Penalty  in  1  one-cycle pulse: subtract P_PENALTY seconds
- i_Pause  in  1  level; freezes counting while high
- o_Remain  out  P_CNT_W  seconds remaining (for display)
- o_IntervalTick  out  1  one-cycle pulse every P_INTERVAL elapsed seconds
- o_ExpireTick  out  1  one-cycle pulse when remaining reaches 0
- o_Warn  out  1  level, low-time warning
- o_Running  out  1  level, FSM in RUN

## Operation
- Internal FSM: S_IDLE, S_RUN, S_PAUSE, S_EXPIRED, S_HOLD.
- S_IDLE: remain=P_LIMIT, elapsed=0. Moves to S_RUN when i_State==001.
- S_RUN: on i_Sec1Tick, elapsed+=1 and remain-=1. On i_Penalty, remain-=P_PENALTY. When both occur in the same cycle, remain-=1+P_PENALTY. Remain saturates at 0 and never wraps.
- o_IntervalTick fires when the new elapsed value is a nonzero multiple of P_INTERVAL. It is driven only by second ticks; penalties never fire it.
- When remain becomes 0 from any source: o_ExpireTick fires and the FSM goes to S_EXPIRED. If the interval condition holds in the same update, both pulses fire together.
- S_RUN with i_Pause=1 goes to S_PAUSE. There, ticks and penalties are ignored. i_Pause=0 returns the FSM to S_RUN.
- i_State 010/011 from S_RUN/S_PAUSE/S_EXPIRED goes to S_HOLD. S_HOLD freezes o_Remain for display.
- i_State 000 from any state goes to S_IDLE and reloads.
- Re-entering 001 from S_HOLD goes through reload, i.e. a fresh game.
- S_EXPIRED holds remain=0 and emits no further pulses.
- o_Warn = (remain ≤ P_WARN) and state ∈ {S_RUN, S_PAUSE, S_EXPIRED}.

## Timing
- All outputs are registered.
- Reset values: o_Remain=P_LIMIT, o_IntervalTick=0, o_ExpireTick=0, o_Warn=0, o_Running=0, FSM=S_IDLE, elapsed=0.
- Reset is sampled on the rising edge of i_Clk. Reset mid-game aborts the game with no pulses.
- Latency: an event sampled at edge N updates o_Remain and the pulses, visible after edge N. Each pulse is high exactly one cycle.
- Pulses always fall at the next edge, even if the input tick is held high for several cycles. Each sampled-high cycle counts as one event.
- If an event and a change of i_State occur in the same cycle, the i_State change wins and the event is dropped.
- If an event and i_Pause rising occur in the same cycle, the event is applied first, then the FSM enters S_PAUSE.

## Structure
- Shared package holds: the i_State codes (idle/game_start/game_clear/game_fail, also used by the game FSM) and the timer FSM state encoding.
- One sub-module, interval_cnt: a modulo-P_INTERVAL counter that advances on i_Sec1Tick and flags wrap. It is cleared on reload, which avoids a divider.
- Saturating subtract and the FSM live in game_timer.

## Test plan
- Defaults; i_State=001; 30 ticks 1000 cycles apart → o_Remain 30→0; o_IntervalTick at elapsed 10, 20, 30; o_ExpireTick with the 30th tick; o_Warn from remain=5.
- Penalty at remain=12 → remain 9. Penalty at remain=2 → remain saturates at 0, o_ExpireTick=1, o_IntervalTick=0.
- Penalty coincident with tick at remain=10 → remain 6. Interval tick fires if elapsed becomes a multiple of 10.
- i_Pause high for 5 ticks at remain=20 → remain stays 20, no pulses. Release, then 1 tick → remain 19.
- i_State 001→010 at remain=17 → o_Remain holds 17 and o_Running=0. Then 010→000 → remain 30. Back to 001 → fresh count.
- i_Rst=0 for one cycle at remain=8 → all outputs at reset values next cycle. i_Sec1Tick held high 3 cycles → remain drops by 3, pulses stay single-cycle.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared definitions for the bomb-game timer: game-state codes driven by the
// game-control FSM and the timer's own FSM state encoding.
package game_timer_pkg;

  // Game-state codes on i_State; also used by the game-control FSM.
  typedef enum logic [2:0] {
    GS_IDLE  = 3'b000,
    GS_START = 3'b001,
    GS_CLEAR = 3'b010,
    GS_FAIL  = 3'b011
  } game_state_e;

  // Timer FSM states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PAUSE   = 3'd2,
    S_EXPIRED = 3'd3,
    S_HOLD    = 3'd4
  } tmr_state_e;

  // True when the game is actively being played.
  function automatic logic gs_is_start(input logic [2:0] s);
    return s == GS_START;
  endfunction

  // True when the game has ended (cleared or failed); display must freeze.
  function automatic logic gs_is_end(input logic [2:0] s);
    return (s == GS_CLEAR) || (s == GS_FAIL);
  endfunction

endpackage

// File: rtl/game_timer_interval_cnt.sv
// Modulo-P_INTERVAL elapsed-second counter. Flags the tick that completes an
// interval so the top never has to divide the elapsed count.
module game_timer_interval_cnt #(
  parameter int P_CNT_W    = 6,
  parameter int P_INTERVAL = 10
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_Adv,
  output logic o_Wrap
);

  localparam logic [P_CNT_W-1:0] LAST_V = P_CNT_W'(P_INTERVAL - 1);

  logic [P_CNT_W-1:0] cnt_q;
  logic [P_CNT_W-1:0] cnt_d;

  // The advancing tick lands on a multiple of the interval.
  assign o_Wrap = i_Adv && (cnt_q == LAST_V);

  // Next count: clear on reload, otherwise advance and wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr) begin
      cnt_d = '0;
    end else if (i_Adv) begin
      cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Countdown timer for the bomb game. Counts seconds down from P_LIMIT while the
// game runs, applies penalties, supports pause, and emits registered interval,
// expiry and warning indications for the game FSM and display.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int P_CNT_W    = 6,
  parameter int P_LIMIT    = 30,
  parameter int P_INTERVAL = 10,
  parameter int P_PENALTY  = 3,
  parameter int P_WARN     = 5
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [2:0]         i_State,
  input  logic               i_Sec1Tick,
  input  logic               i_Penalty,
  input  logic               i_Pause,
  output logic [P_CNT_W-1:0] o_Remain,
  output logic               o_IntervalTick,
  output logic               o_ExpireTick,
  output logic               o_Warn,
  output logic               o_Running
);

  localparam logic [P_CNT_W-1:0] LIMIT_V = P_CNT_W'(P_LIMIT);
  localparam logic [P_CNT_W-1:0] WARN_V  = P_CNT_W'(P_WARN);
  localparam logic [P_CNT_W:0]   PEN_V   = (P_CNT_W + 1)'(P_PENALTY);
  localparam logic [P_CNT_W:0]   ONE_V   = (P_CNT_W + 1)'(1);

  // Subtract with a floor at zero; b is one bit wider so 1+P_PENALTY fits.
  function automatic logic [P_CNT_W-1:0] sat_sub(input logic [P_CNT_W-1:0] a,
                                                 input logic [P_CNT_W:0]   b);
    logic [P_CNT_W:0] diff;
    diff = {1'b0, a} - b;
    if (b >= {1'b0, a}) return '0;
    return diff[P_CNT_W-1:0];
  endfunction

  tmr_state_e         state_q, state_d;
  logic [P_CNT_W-1:0] remain_q, remain_d;
  logic               itick_q, itick_d;
  logic               etick_q, etick_d;
  logic               warn_q, warn_d;
  logic               run_q, run_d;

  logic               go_start, go_end, go_idle;
  logic               tick_ev, pen_ev, wrap;
  logic [P_CNT_W:0]   dec_amt;
  logic [P_CNT_W-1:0] remain_sub;

  // Decode the game state; unknown codes behave as idle.
  assign go_start = gs_is_start(i_State);
  assign go_end   = gs_is_end(i_State);
  assign go_idle  = !go_start && !go_end;

  // Events only count while running and the game state stays at game_start,
  // so a simultaneous state change drops the event.
  assign tick_ev    = (state_q == S_RUN) && go_start && i_Sec1Tick;
  assign pen_ev     = (state_q == S_RUN) && go_start && i_Penalty;
  assign dec_amt    = (tick_ev ? ONE_V : '0) + (pen_ev ? PEN_V : '0);
  assign remain_sub = sat_sub(remain_q, dec_amt);

  game_timer_interval_cnt #(
    .P_CNT_W    (P_CNT_W),
    .P_INTERVAL (P_INTERVAL)
  ) interval_cnt (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Clr  (state_q == S_IDLE),
    .i_Adv  (tick_ev),
    .o_Wrap (wrap)
  );

  // Next-state and next-output logic of the timer FSM.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    itick_d  = 1'b0;
    etick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        remain_d = LIMIT_V;
        if (go_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (go_idle) begin
          state_d  = S_IDLE;
          remain_d = LIMIT_V;
        end else if (go_end) begin
          state_d = S_HOLD;
        end else begin
          remain_d = remain_sub;
          itick_d  = wrap;
          if (remain_sub == '0) begin
            etick_d = 1'b1;
            state_d = S_EXPIRED;
          end else if (i_Pause) begin
            state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (go_idle) begin
          state_d  = S_IDLE;
          remain_d = LIMIT_V;
        end else if (go_end) begin
          state_d = S_HOLD;
        end else if (!i_Pause) begin
          state_d = S_RUN;
        end
      end
      S_EXPIRED: begin
        remain_d = '0;
        if (go_idle) begin
          state_d  = S_IDLE;
          remain_d = LIMIT_V;
        end else if (go_end) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // A new game_start also passes through the reload in S_IDLE.
        if (go_idle || go_start) begin
          state_d  = S_IDLE;
          remain_d = LIMIT_V;
        end
      end
      default: begin
        state_d  = S_IDLE;
        remain_d = LIMIT_V;
      end
    endcase
    run_d  = (state_d == S_RUN);
    warn_d = ((state_d == S_RUN) || (state_d == S_PAUSE) || (state_d == S_EXPIRED))
             && (remain_d <= WARN_V);
  end

  // FSM state and registered outputs with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q  <= S_IDLE;
      remain_q <= LIMIT_V;
      itick_q  <= 1'b0;
      etick_q  <= 1'b0;
      warn_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      itick_q  <= itick_d;
      etick_q  <= etick_d;
      warn_q   <= warn_d;
      run_q    <= run_d;
    end
  end

  assign o_Remain       = remain_q;
  assign o_IntervalTick = itick_q;
  assign o_ExpireTick   = etick_q;
  assign o_Warn         = warn_q;
  assign o_Running      = run_q;

endmodule
